// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter.
// Inhibits the bus, issues request-to-send, shifts out an 11-bit frame
// (start, 8 data LSB first, odd parity, stop) on device clock falling edges,
// samples the device ACK, then waits for the bus to return idle.
// Open-drain style: *_oe = 1 pulls the corresponding line low.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [7:0] din,
  input  logic       ps2c_in,
  input  logic       ps2d_in,
  output logic       ps2c_oe,
  output logic       ps2d_oe,
  output logic       busy,
  output logic       tx_done_tick,
  output logic       ack_ok,
  output logic       tx_error
);

  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    RTS,
    SEND,
    ACK,
    WAIT_IDLE
  } state_t;

  state_t          state, state_next;
  logic [7:0]      filt_reg;
  logic            filt_val;
  logic            fall_edge;
  logic            ps2d_p0, ps2d_p1;
  logic [IW-1:0]   inh_cnt, inh_cnt_next;
  logic [TW-1:0]   to_cnt, to_cnt_next;
  logic [3:0]      bit_cnt, bit_cnt_next;
  logic [8:0]      frame_sh, frame_sh_next;
  logic            ack_ok_next;
  logic            ps2c_oe_next, ps2d_oe_next, busy_next, done_next, err_next;
  logic            accept, timed, timeout, done_cond;

  // Glitch filter on the device clock: level flips only after eight equal samples.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      filt_reg <= 8'hFF;
      filt_val <= 1'b1;
    end else begin
      filt_reg <= {ps2c_in, filt_reg[7:1]};
      if (filt_reg == 8'hFF)
        filt_val <= 1'b1;
      else if (filt_reg == 8'h00)
        filt_val <= 1'b0;
    end
  end

  // Falling edge of the filtered clock: level still high while the window is all zeros.
  assign fall_edge = filt_val && (filt_reg == 8'h00);

  // Two-flop synchronizer for the asynchronous data line.
  always_ff @(posedge CLOCK_50) begin
    ps2d_p0 <= ps2d_in;
    ps2d_p1 <= ps2d_p0;
  end

  // Frame shift register: {parity, din}; bit 0 is the next bit to present.
  always_ff @(posedge CLOCK_50) begin
    frame_sh <= frame_sh_next;
  end

  // A request counts only in IDLE and not while a completion/abort pulse is showing.
  assign accept    = (state == IDLE) && wr_en && !tx_done_tick && !tx_error;
  assign timed     = (state == RTS) || (state == SEND) || (state == ACK) || (state == WAIT_IDLE);
  assign done_cond = (state == WAIT_IDLE) && filt_val && ps2d_p1;
  assign timeout   = timed && !fall_edge && !done_cond && (to_cnt == TO_LAST);

  // State, counters and registered outputs.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state        <= IDLE;
      inh_cnt      <= '0;
      to_cnt       <= '0;
      bit_cnt      <= '0;
      ack_ok       <= 1'b0;
      ps2c_oe      <= 1'b0;
      ps2d_oe      <= 1'b0;
      busy         <= 1'b0;
      tx_done_tick <= 1'b0;
      tx_error     <= 1'b0;
    end else begin
      state        <= state_next;
      inh_cnt      <= inh_cnt_next;
      to_cnt       <= to_cnt_next;
      bit_cnt      <= bit_cnt_next;
      ack_ok       <= ack_ok_next;
      ps2c_oe      <= ps2c_oe_next;
      ps2d_oe      <= ps2d_oe_next;
      busy         <= busy_next;
      tx_done_tick <= done_next;
      tx_error     <= err_next;
    end
  end

  // Next-state logic, counter updates and frame bookkeeping.
  always_comb begin
    state_next    = state;
    inh_cnt_next  = inh_cnt;
    to_cnt_next   = to_cnt;
    bit_cnt_next  = bit_cnt;
    frame_sh_next = frame_sh;
    ack_ok_next   = ack_ok;

    // Timeout counter restarts on every device clock edge while the device owns the pacing.
    if (timed)
      to_cnt_next = fall_edge ? '0 : to_cnt + TW'(1);

    unique case (state)
      IDLE: begin
        to_cnt_next = '0;
        if (accept) begin
          state_next    = INHIBIT;
          inh_cnt_next  = '0;
          bit_cnt_next  = '0;
          frame_sh_next = {~^din, din};
        end
      end
      INHIBIT: begin
        if (inh_cnt == INH_LAST) begin
          state_next  = RTS;
          to_cnt_next = '0;
        end else begin
          inh_cnt_next = inh_cnt + IW'(1);
        end
      end
      RTS: begin
        if (fall_edge) begin
          state_next    = SEND;
          bit_cnt_next  = 4'd1;
          frame_sh_next = {1'b0, frame_sh[8:1]};
        end
      end
      SEND: begin
        if (fall_edge) begin
          if (bit_cnt == 4'd9) begin
            state_next = ACK;
          end else begin
            bit_cnt_next  = bit_cnt + 4'd1;
            frame_sh_next = {1'b0, frame_sh[8:1]};
          end
        end
      end
      ACK: begin
        if (fall_edge) begin
          ack_ok_next = ~ps2d_p1;
          state_next  = WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        if (done_cond)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    if (timeout)
      state_next = IDLE;
  end

  // Output values for the coming cycle, derived from where the FSM is heading.
  always_comb begin
    ps2c_oe_next = 1'b0;
    ps2d_oe_next = 1'b0;
    busy_next    = (state_next != IDLE);
    done_next    = done_cond;
    err_next     = timeout;
    unique case (state_next)
      INHIBIT: begin
        ps2c_oe_next = 1'b1;
        ps2d_oe_next = (inh_cnt_next == INH_LAST);
      end
      RTS:     ps2d_oe_next = 1'b1;
      SEND:    ps2d_oe_next = fall_edge ? ~frame_sh[0] : ps2d_oe;
      default: ps2d_oe_next = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain bus model plus a behavioural PS/2 device.
// Frames are checked against a reference that builds the expected 11-bit
// line sequence arithmetically from the byte.
module tb_ps2_host_tx;

  localparam int INH      = 50;
  localparam int TO       = 1000;
  localparam int HALF     = 20;
  // Device clock drop to recognised edge: eight low samples, then the level flips.
  localparam int EDGE_LAT = 9;

  logic       CLOCK_50 = 1'b0;
  logic       reset, wr_en;
  logic [7:0] din;
  logic       dev_clk, dev_dat;
  logic       ps2c_in, ps2d_in;
  logic       ps2c_oe, ps2d_oe, busy, tx_done_tick, ack_ok, tx_error;

  assign ps2c_in = dev_clk & ~ps2c_oe;
  assign ps2d_in = dev_dat & ~ps2d_oe;

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;
  int err_cyc = 0;
  logic err_c, err_d, err_b;

  int          inh_len, d_first, edge4_cyc;
  logic        rts_d;
  logic [10:0] got_word;

  typedef struct {
    logic [7:0] d;
    bit         ack;
    bit         exp_ack;
    int         exp_done;
    int         exp_err;
  } vec_t;

  vec_t vecs[5];

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
    .CLOCK_50    (CLOCK_50),
    .reset       (reset),
    .wr_en       (wr_en),
    .din         (din),
    .ps2c_in     (ps2c_in),
    .ps2d_in     (ps2d_in),
    .ps2c_oe     (ps2c_oe),
    .ps2d_oe     (ps2d_oe),
    .busy        (busy),
    .tx_done_tick(tx_done_tick),
    .ack_ok      (ack_ok),
    .tx_error    (tx_error)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  always @(posedge CLOCK_50) cyc <= cyc + 1;

  // Pulse monitor, sampled away from the active edge.
  always @(negedge CLOCK_50) begin
    if (tx_done_tick) done_cnt++;
    if (tx_error) begin
      err_cnt++;
      err_cyc = cyc;
      err_c   = ps2c_oe;
      err_d   = ps2d_oe;
      err_b   = busy;
    end
    if (tx_done_tick && tx_error) both_cnt++;
  end

  initial begin
    #4000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected line sequence: start 0, data LSB first, odd parity, stop 1.
  function automatic logic [10:0] model_frame(input logic [7:0] d);
    int w;
    w = int'(d) * 2;
    if ($countones(d) % 2 == 0) w += 512;
    w += 1024;
    return 11'(w);
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  task automatic send_req(input logic [7:0] d);
    din   = d;
    wr_en = 1'b1;
    tick(1);
    wr_en = 1'b0;
  endtask

  // Device side: measure inhibit, then clock out up to n_edges pulses, sampling data on the rising half.
  task automatic device_frame(input bit ack, input int n_edges);
    int n;
    inh_len  = 0;
    d_first  = 0;
    got_word = '0;
    n = 0;
    while (!ps2c_oe && n < 10) begin tick(1); n++; end
    while (ps2c_oe && inh_len < 4 * INH) begin
      inh_len++;
      if (ps2d_oe && d_first == 0) d_first = inh_len;
      tick(1);
    end
    rts_d = ps2d_oe;
    tick(30);
    for (int e = 1; e <= 11 && e <= n_edges; e++) begin
      if (e == 1) got_word[0] = ps2d_in;
      if (e == 11 && ack) begin dev_dat = 1'b0; tick(5); end
      dev_clk = 1'b0;
      if (e == 4) edge4_cyc = cyc;
      tick(HALF);
      if (e <= 10) got_word[e] = ps2d_in;
      dev_clk = 1'b1;
      tick(HALF);
      dev_dat = 1'b1;
    end
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 3 * TO) begin tick(1); n++; end
    check({tag, "_idle"}, busy, 0);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int d0, e0;
    d0 = done_cnt;
    e0 = err_cnt;
    send_req(v.d);
    check({tag, "_busy"}, busy, 1);
    device_frame(v.ack, 11);
    wait_idle(tag);
    tick(3);
    check({tag, "_frame"}, got_word, model_frame(v.d));
    check({tag, "_inh_len"}, inh_len, INH);
    check({tag, "_d_first"}, d_first, INH);
    check({tag, "_rts_d"}, rts_d, 1);
    check({tag, "_ack"}, ack_ok, v.exp_ack);
    check({tag, "_done"}, done_cnt - d0, v.exp_done);
    check({tag, "_err"}, err_cnt - e0, v.exp_err);
  endtask

  initial begin
    int   d0, e0, n;
    logic prev_ack;
    vec_t fresh;

    vecs[0] = '{d: 8'hED, ack: 1'b1, exp_ack: 1'b1, exp_done: 1, exp_err: 0};
    vecs[1] = '{d: 8'h00, ack: 1'b0, exp_ack: 1'b0, exp_done: 1, exp_err: 0};
    vecs[2] = '{d: 8'hFF, ack: 1'b1, exp_ack: 1'b1, exp_done: 1, exp_err: 0};
    vecs[3] = '{d: 8'hA5, ack: 1'b0, exp_ack: 1'b0, exp_done: 1, exp_err: 0};
    vecs[4] = '{d: 8'h81, ack: 1'b1, exp_ack: 1'b1, exp_done: 1, exp_err: 0};

    reset   = 1'b1;
    wr_en   = 1'b0;
    din     = 8'h00;
    dev_clk = 1'b1;
    dev_dat = 1'b1;
    tick(3);
    check("rst_ps2c_oe", ps2c_oe, 0);
    check("rst_ps2d_oe", ps2d_oe, 0);
    check("rst_busy", busy, 0);
    check("rst_done", tx_done_tick, 0);
    check("rst_err", tx_error, 0);
    check("rst_ack", ack_ok, 0);
    reset = 1'b0;
    tick(2);

    for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Device goes silent after four clock edges.
    prev_ack = ack_ok;
    d0 = done_cnt;
    e0 = err_cnt;
    send_req(8'h5A);
    device_frame(1'b1, 4);
    n = 0;
    while (err_cnt == e0 && n < 3 * TO) begin tick(1); n++; end
    tick(2);
    check("to_err_pulse", err_cnt - e0, 1);
    check("to_latency", err_cyc - edge4_cyc, TO + EDGE_LAT);
    check("to_c_oe", err_c, 0);
    check("to_d_oe", err_d, 0);
    check("to_busy", err_b, 0);
    check("to_ack_kept", ack_ok, prev_ack);
    check("to_no_done", done_cnt - d0, 0);

    // Second request while a frame is in flight.
    d0 = done_cnt;
    send_req(8'h3C);
    fork
      device_frame(1'b1, 11);
      begin
        tick(200);
        check("mid_busy_at_wr", busy, 1);
        din   = 8'hFF;
        wr_en = 1'b1;
        tick(1);
        wr_en = 1'b0;
      end
    join
    wait_idle("mid");
    tick(5);
    check("mid_frame", got_word, model_frame(8'h3C));
    check("mid_done", done_cnt - d0, 1);
    check("mid_no_restart", ps2c_oe, 0);
    check("mid_ack", ack_ok, 1);

    // Request coinciding with the completion pulse.
    send_req(8'h12);
    device_frame(1'b1, 11);
    n = 0;
    while (!tx_done_tick && n < 200) begin tick(1); n++; end
    check("dc_done_seen", tx_done_tick, 1);
    din   = 8'hAB;
    wr_en = 1'b1;
    tick(1);
    wr_en = 1'b0;
    check("dc_busy", busy, 0);
    tick(5);
    check("dc_no_inhibit", ps2c_oe, 0);
    check("dc_frame", got_word, model_frame(8'h12));

    // Reset in the middle of SEND (bit 2 of 0x7B is 0, so data is being driven low).
    d0 = done_cnt;
    e0 = err_cnt;
    send_req(8'h7B);
    device_frame(1'b0, 3);
    check("rst_pre_d", ps2d_oe, 1);
    reset = 1'b1;
    tick(1);
    check("rstm_c_oe", ps2c_oe, 0);
    check("rstm_d_oe", ps2d_oe, 0);
    check("rstm_busy", busy, 0);
    reset = 1'b0;
    tick(TO + 100);
    check("rstm_no_done", done_cnt - d0, 0);
    check("rstm_no_err", err_cnt - e0, 0);
    fresh = '{d: 8'h7B, ack: 1'b1, exp_ack: 1'b1, exp_done: 1, exp_err: 0};
    run_vec(fresh, "fresh");

    // Randomised frames against the reference model.
    for (int i = 0; i < 6; i++) begin
      vec_t v;
      v.d        = 8'($urandom_range(0, 255));
      v.ack      = 1'($urandom_range(0, 1));
      v.exp_ack  = v.ack;
      v.exp_done = 1;
      v.exp_err  = 0;
      run_vec(v, $sformatf("rnd%0d", i));
    end

    check("never_both", both_cnt, 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
